// File: rtl/lfsr_rng_pkg.sv
// lfsr_pkg: shared types, constants and step function for the lfsr_rng slice.
//   lfsr_fsm_e    : draw FSM state encoding (IDLE / SHIFT / VALID)
//   DEFAULT_TAPS  : x^32 + x^22 + x^2 + x + 1 Galois feedback mask
//   DEFAULT_SEED  : reset / recovery state
//   lfsr_step()   : one Galois shift, evaluated on a LFSR_MAX_W-wide container
//                   so one function serves every instance width (WIDTH <= 64).
package lfsr_pkg;

   localparam int          LFSR_MAX_W   = 64;
   localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'h2048_FAFA;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      VALID = 2'd2
   } lfsr_fsm_e;

   // Right shift, folding the feedback mask in when the bit falling out is 1.
   // Callers zero-extend state and taps, so the upper container bits stay 0.
   function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
      input logic [LFSR_MAX_W-1:0] s,
      input logic [LFSR_MAX_W-1:0] taps
   );
      return (s >> 1) ^ (s[0] ? taps : '0);
   endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// lfsr_rng_if: draw handshake between the game controller (master) and the
// random-number engine (slave).
//   req       master -> slave  request a draw
//   rnd_ready master -> slave  consumer accepts rnd_out
//   rnd_valid slave -> master  rnd_out holds a completed draw
//   rnd_out   slave -> master  OUT_W-bit symbol
//   busy      slave -> master  engine is not idle
interface lfsr_rng_if #(
   parameter int OUT_W = 2
) ();

   logic             req;
   logic             rnd_ready;
   logic             rnd_valid;
   logic [OUT_W-1:0] rnd_out;
   logic             busy;

   modport master (
      output req,
      output rnd_ready,
      input  rnd_valid,
      input  rnd_out,
      input  busy
   );

   modport slave (
      input  req,
      input  rnd_ready,
      output rnd_valid,
      output rnd_out,
      output busy
   );

endinterface

// File: rtl/lfsr_rng_core.sv
// lfsr_core: LFSR state register with step logic, seed load, zero-lock
// recovery and an optional snapshot register.
// Optional feature macro: LFSR_REPLAY_EN (mark/rewind snapshot support).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (state and snapshot -> SEED)
//   step_en      advance the state by one Galois shift this cycle
//   load_en      load load_value (0 is replaced by SEED); highest priority
//   load_value   seed to load
//   mark         copy the current state into the snapshot (replay build only)
//   rewind       restore the state from the snapshot (replay build only)
//   state_out    current state
//   next_bits    low OUT_W bits of the state about to be registered
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
   parameter int               OUT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step_en,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_value,
   input  logic             mark,
   input  logic             rewind,
   output logic [WIDTH-1:0] state_out,
   output logic [OUT_W-1:0] next_bits
);

   logic [WIDTH-1:0]      state_reg;
   logic [LFSR_MAX_W-1:0] step_wide;
   logic [WIDTH-1:0]      step_val;
   logic [WIDTH-1:0]      load_val;
   logic                  restore_en;
   logic [WIDTH-1:0]      restore_val;

   // Continuous next-state net: the whole priority chain in one expression.
   wire  [WIDTH-1:0]      state_next;

   assign step_wide = lfsr_step(LFSR_MAX_W'(state_reg), LFSR_MAX_W'(TAPS));
   assign step_val  = step_wide[WIDTH-1:0];

   generate
      if (WIDTH < LFSR_MAX_W) begin : g_step_hi
         // Upper container bits are always zero; consumed here to keep lint quiet.
         logic unused_step_hi;
         assign unused_step_hi = |step_wide[LFSR_MAX_W-1:WIDTH];
      end
   endgenerate

   // An all-zero state would lock the LFSR forever, so a zero load means SEED.
   assign load_val = (load_value == '0) ? SEED : load_value;

`ifdef LFSR_REPLAY_EN
   logic [WIDTH-1:0] snap_reg;

   // load_en and rewind outrank mark, so a mark coinciding with either is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_reg <= SEED;
      end else if (mark && !load_en && !rewind) begin
         snap_reg <= state_reg;
      end
   end

   assign restore_en  = rewind;
   assign restore_val = snap_reg;
`else
   logic unused_replay;
   assign unused_replay = mark | rewind;
   assign restore_en    = 1'b0;
   assign restore_val   = SEED;
`endif

   // Priority: load, rewind, zero-lock recovery, step, hold.
   assign state_next = load_en             ? load_val    :
                       restore_en          ? restore_val :
                       (state_reg == '0)   ? SEED        :
                       step_en             ? step_val    :
                                             state_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= SEED;
      end else begin
         state_reg <= state_next;
      end
   end

   assign state_out = state_reg;
   assign next_bits = state_next[OUT_W-1:0];

endmodule

// File: rtl/lfsr_rng.sv
// lfsr_rng: Galois LFSR random-number engine with a req/valid draw handshake.
// The LFSR free-runs in IDLE (when free_run=1) so user timing adds entropy;
// each draw performs STEPS shifts and presents the low OUT_W bits.
// Optional feature macro: LFSR_REPLAY_EN (mark/rewind replay of a symbol run).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   free_run     step the state every IDLE cycle without a request
//   load_en      load load_value (0 -> SEED), abort any draw; highest priority
//   load_value   WIDTH-bit seed
//   mark         snapshot the state (replay build only)
//   rewind       restore the snapshot and abort any draw (replay build only)
//   state_out    current LFSR state (debug / seed export)
//   draw         lfsr_rng_if slave: req, rnd_ready, rnd_valid, rnd_out, busy
module lfsr_rng
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
   parameter int               STEPS = 2,
   parameter int               OUT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             free_run,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_value,
   input  logic             mark,
   input  logic             rewind,
   output logic [WIDTH-1:0] state_out,
   lfsr_rng_if.slave        draw
);

   lfsr_fsm_e        fsm_reg, fsm_next;
   logic [7:0]       cnt_reg, cnt_next;
   logic [OUT_W-1:0] rnd_out_reg, rnd_out_next;
   logic             step_en;
   logic             rewind_hit;
   logic [OUT_W-1:0] next_bits;

`ifdef LFSR_REPLAY_EN
   assign rewind_hit = rewind;
`else
   assign rewind_hit = 1'b0;
`endif

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED),
      .OUT_W (OUT_W)
   ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .step_en    (step_en),
      .load_en    (load_en),
      .load_value (load_value),
      .mark       (mark),
      .rewind     (rewind),
      .state_out  (state_out),
      .next_bits  (next_bits)
   );

   always_comb begin
      fsm_next     = fsm_reg;
      cnt_next     = cnt_reg;
      rnd_out_next = rnd_out_reg;
      step_en      = 1'b0;

      if (load_en || rewind_hit) begin
         // Abort whatever is in flight; rnd_out keeps its last completed value.
         fsm_next = IDLE;
      end else begin
         case (fsm_reg)
            IDLE: begin
               if (draw.req) begin
                  // The accepting cycle does not shift, so the draw costs STEPS shifts.
                  fsm_next = SHIFT;
                  cnt_next = 8'(STEPS - 1);
               end else begin
                  step_en = free_run;
               end
            end
            SHIFT: begin
               step_en = 1'b1;
               if (cnt_reg == '0) begin
                  // Capture the value being registered on this same edge.
                  rnd_out_next = next_bits;
                  fsm_next     = VALID;
               end else begin
                  cnt_next = cnt_reg - 8'd1;
               end
            end
            VALID: begin
               // State frozen; a req in the accept cycle is deliberately dropped.
               if (draw.rnd_ready) begin
                  fsm_next = IDLE;
               end
            end
            default: begin
               fsm_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_reg     <= IDLE;
         cnt_reg     <= '0;
         rnd_out_reg <= '0;
      end else begin
         fsm_reg     <= fsm_next;
         cnt_reg     <= cnt_next;
         rnd_out_reg <= rnd_out_next;
      end
   end

   assign draw.rnd_valid = (fsm_reg == VALID);
   assign draw.busy      = (fsm_reg != IDLE);
   assign draw.rnd_out   = rnd_out_reg;

endmodule
